signed_divider: RTL and testbench

Sequential 8-bit signed integer divider, the inverse companion of the sequential signed multiplier in the arithmetic datapath. It takes a signed dividend and divisor, strips the signs to magnitudes, and runs an 8-iteration restoring division on the magnitudes. It then re-applies the signs to produce a truncating quotient and remainder. A start/busy/done handshake connects it to the datapath controller, and dedicated flags report divide-by-zero and overflow.

---
 rtl/signed_div_pkg.sv | 14 +
 rtl/twos_complement.sv | 12 +
 rtl/unsigned_divider.sv | 73 +++++++
 rtl/signed_divider.sv | 143 ++++++++++++++
 tb/tb_signed_divider.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/signed_div_pkg.sv
// Shared types and constants for the sequential signed divider.
package signed_div_pkg;

    localparam int DIV_WIDTH  = 8;
    localparam int ITER_COUNT = DIV_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIX    = 2'd2,
        DONE   = 2'd3
    } div_state_e;

endpackage

// File: rtl/twos_complement.sv
// Conditional two's-complement negation, used for sign strip and sign restore.
module twos_complement #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in_val,
    input  logic             negate,
    output logic [WIDTH-1:0] out_val
);

    assign out_val = negate ? (~in_val + {{(WIDTH-1){1'b0}}, 1'b1}) : in_val;

endmodule

// File: rtl/unsigned_divider.sv
// Restoring shift/subtract core on unsigned magnitudes, sequenced by load/step.
module unsigned_divider
    import signed_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend_mag,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH-1:0] q_mag,
    output logic [WIDTH-1:0] r_mag,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] pr_q,  pr_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   trial_s;

    // Next-state for one restoring iteration; the 9-bit trial borrow selects restore.
    always_comb begin
        pr_d      = pr_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        shifted_s = {pr_q, quo_q[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, dvs_q};
        if (load) begin
            pr_d  = {WIDTH{1'b0}};
            quo_d = dividend_mag;
            dvs_d = divisor_mag;
            cnt_d = {CW{1'b0}};
        end else if (step) begin
            if (trial_s[WIDTH]) begin
                pr_d  = shifted_s[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end else begin
                pr_d  = trial_s[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Core state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pr_q  <= {WIDTH{1'b0}};
            quo_q <= {WIDTH{1'b0}};
            dvs_q <= {WIDTH{1'b0}};
            cnt_q <= {CW{1'b0}};
        end else begin
            pr_q  <= pr_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    assign q_mag = quo_q;
    assign r_mag = pr_q;
    assign last  = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/signed_divider.sv
// Sequential signed divider: sign strip, restoring core, sign restore, start/busy/done handshake.
module signed_divider
    import signed_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             overflow
);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             dz_q, dz_d, ovf_q, ovf_d;
    logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic             load_s, step_s, last_s;
    logic [WIDTH-1:0] dvd_mag_s, dvs_mag_s, q_mag_s, r_mag_s, q_fix_s, r_fix_s;

    twos_complement #(.WIDTH(WIDTH)) u_abs_dvd (.in_val(dividend), .negate(dividend[WIDTH-1]), .out_val(dvd_mag_s));
    twos_complement #(.WIDTH(WIDTH)) u_abs_dvs (.in_val(divisor),  .negate(divisor[WIDTH-1]),  .out_val(dvs_mag_s));
    twos_complement #(.WIDTH(WIDTH)) u_fix_quo (.in_val(q_mag_s),  .negate(neg_quo_q),         .out_val(q_fix_s));
    twos_complement #(.WIDTH(WIDTH)) u_fix_rem (.in_val(r_mag_s),  .negate(neg_rem_q),         .out_val(r_fix_s));

    unsigned_divider #(.WIDTH(WIDTH)) u_core (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load_s),
        .step         (step_s),
        .dividend_mag (dvd_mag_s),
        .divisor_mag  (dvs_mag_s),
        .q_mag        (q_mag_s),
        .r_mag        (r_mag_s),
        .last         (last_s)
    );

    // Controller next-state; DONE accepts a new start so back-to-back issue works.
    always_comb begin
        state_d    = state_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dz_d       = dz_q;
        ovf_d      = ovf_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        ovf_pend_d = ovf_pend_q;
        load_s     = 1'b0;
        step_s     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                busy_d = 1'b0;
                if (start) begin
                    if (divisor == {WIDTH{1'b0}}) begin
                        quo_d   = {WIDTH{1'b1}};
                        rem_d   = dividend;
                        dz_d    = 1'b1;
                        ovf_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        load_s     = 1'b1;
                        neg_quo_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_rem_d  = dividend[WIDTH-1];
                        ovf_pend_d = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                                     (divisor == {WIDTH{1'b1}});
                        dz_d       = 1'b0;
                        ovf_d      = 1'b0;
                        busy_d     = 1'b1;
                        state_d    = DIVIDE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DIVIDE: begin
                step_s = 1'b1;
                if (last_s) begin
                    state_d = FIX;
                end else begin
                    state_d = DIVIDE;
                end
            end
            FIX: begin
                quo_d   = q_fix_s;
                rem_d   = r_fix_s;
                ovf_d   = ovf_pend_q;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            quo_q      <= {WIDTH{1'b0}};
            rem_q      <= {WIDTH{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            ovf_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dz_q       <= dz_d;
            ovf_q      <= ovf_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            ovf_pend_q <= ovf_pend_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign div_zero  = dz_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_signed_divider.sv
// Scoreboard bench for signed_divider: arithmetic reference model, queued expectations, done-driven monitor.
module tb_signed_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = 8'h00;
    logic [7:0] divisor = 8'h00;
    logic [7:0] quotient, remainder;
    logic       busy, done, div_zero, overflow;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ov;
        int         cyc;
        logic [7:0] a;
        logic [7:0] b;
    } exp_t;

    exp_t sb_q[$];

    signed_divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int start_cyc);
        exp_t e;
        int sa, sb, qi, ri;
        sa = int'($signed(a));
        sb = int'($signed(b));
        e.a = a;
        e.b = b;
        if (sb == 0) begin
            e.q = 8'hFF;
            e.r = a;
            e.dz = 1'b1;
            e.ov = 1'b0;
            e.cyc = start_cyc;
        end else begin
            qi = sa / sb;
            ri = sa % sb;
            e.q = qi[7:0];
            e.r = ri[7:0];
            e.dz = 1'b0;
            e.ov = (sa == -128) && (sb == -1);
            e.cyc = start_cyc + 9;
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: done high at cycle %0d with nothing outstanding", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (quotient !== e.q || remainder !== e.r || div_zero !== e.dz ||
                    overflow !== e.ov || busy !== 1'b0 || cyc != e.cyc) begin
                    fails++;
                    $display("FAIL result %0d/%0d: got q=%h r=%h dz=%b ov=%b busy=%b cyc=%0d, expected q=%h r=%h dz=%b ov=%b busy=0 cyc=%0d",
                             $signed(e.a), $signed(e.b), quotient, remainder, div_zero, overflow,
                             busy, cyc, e.q, e.r, e.dz, e.ov, e.cyc);
                end
            end
        end
    end

    // Issues one operation at the current negedge and returns at the negedge where done is seen.
    task automatic do_div(input logic [7:0] a, input logic [7:0] b, input int repulse);
        int n;
        bit got;
        start = 1'b1;
        dividend = a;
        divisor = b;
        @(posedge clk);
        #1;
        sb_q.push_back(model(a, b, cyc));
        n = 0;
        got = 1'b0;
        while (!got && n < 30) begin
            @(negedge clk);
            n++;
            if (n == repulse) begin
                start = 1'b1;
                dividend = 8'($urandom_range(0, 255));
                divisor = 8'($urandom_range(1, 255));
            end else if (n == 1 || n == repulse + 1) begin
                start = 1'b0;
            end
            if (n == 1 && b != 8'h00) begin
                tests++;
                if (busy !== 1'b1) begin
                    fails++;
                    $display("FAIL busy_rise: got busy=%b, expected 1", busy);
                end
            end
            if (done) got = 1'b1;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL timeout: no done within 30 cycles for %0d/%0d", $signed(a), $signed(b));
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        tests++;
        if (quotient !== 8'h00 || remainder !== 8'h00 || busy !== 1'b0 || done !== 1'b0 ||
            div_zero !== 1'b0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL %s: got q=%h r=%h busy=%b done=%b dz=%b ov=%b, expected all 0",
                     tag, quotient, remainder, busy, done, div_zero, overflow);
        end
    endtask

    initial begin
        logic [7:0] ra, rb;
        repeat (3) @(negedge clk);
        #1;
        check_zero_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_div(8'd100, 8'd7, -1);
        do_div(8'($signed(-100)), 8'd7, -1);
        do_div(8'd100, 8'($signed(-7)), -1);
        do_div(8'h80, 8'hFF, -1);
        do_div(8'h80, 8'h01, -1);
        do_div(8'd5, 8'd0, -1);
        do_div(8'd5, 8'd1, -1);
        do_div(8'h80, 8'h80, -1);
        do_div(8'h7F, 8'h80, -1);
        @(negedge clk);
        do_div(8'd100, 8'd7, 4);

        // Abort mid-operation: reset at cycle 5 must clear everything and suppress done.
        start = 1'b1;
        dividend = 8'd50;
        divisor = 8'd3;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check_zero_outputs("reset_abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        do_div(8'd50, 8'd3, -1);

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 7))
                0:       rb = 8'h00;
                1:       rb = 8'hFF;
                2:       begin rb = 8'hFF; ra = 8'h80; end
                default: rb = 8'($urandom_range(0, 255));
            endcase
            do_div(ra, rb, -1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d results still outstanding, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
